// File: rtl/multi_button_debounce.sv
// multi_button_debounce: N-channel push-button conditioner.
// Each channel has a 2-flop synchroniser, a stability-counter debouncer,
// press/release pulses, and a toggle latch. The LED output of each channel
// shows either the debounced level or the toggle state.
// Define LONG_PRESS_EN to add a per-channel hold counter with a long_press pulse.
// Without it, long_press is tied low.
module multi_button_debounce #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned LONG_CYCLES     = 100,
  parameter int unsigned LONG_W          = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_in,
  input  logic [N_CH-1:0] toggle_mode,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] led_out,
  output logic [N_CH-1:0] long_press
);

  // Terminal count: the stable state flips when the input has disagreed this many times in a row.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (N_CH < 1) begin : g_chk_nch
    $error("multi_button_debounce: N_CH must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("multi_button_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_cntw
    $error("multi_button_debounce: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (LONG_CYCLES < 1) begin : g_chk_long
    $error("multi_button_debounce: LONG_CYCLES must be >= 1");
  end
  if ((64'd1 << LONG_W) <= 64'(LONG_CYCLES)) begin : g_chk_longw
    $error("multi_button_debounce: LONG_W too narrow for LONG_CYCLES");
  end

  logic [N_CH-1:0]  s1_q;
  logic [N_CH-1:0]  s2_q;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  press_q, press_d;
  logic [N_CH-1:0]  release_q, release_d;
  logic [N_CH-1:0]  tog_q, tog_d;

  // Debounce next state: a mismatch run of DEBOUNCE_CYCLES commits the new level.
  // The press and release pulses and the toggle flip are produced from the same event.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    tog_d     = tog_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i]   = s2_q[i];
          press_d[i]   = s2_q[i];
          release_d[i] = ~s2_q[i];
          tog_d[i]     = tog_q[i] ^ s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser and debounce state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '{default: '0};
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      tog_q     <= '0;
    end else begin
      s1_q      <= button_in;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      tog_q     <= tog_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

  // The LED mode selects between registered sources, so a mode change shows immediately.
  assign led_out = (toggle_mode & tog_q) | (~toggle_mode & level_q);

`ifdef LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_FIRE = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] hold_q [N_CH];
  logic [LONG_W-1:0] hold_d [N_CH];
  logic [N_CH-1:0]   long_q, long_d;

  // Hold counter: it counts while the level is high, saturates at LONG_CYCLES, and fires once.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      hold_d[i] = '0;
      if (level_q[i]) begin
        hold_d[i] = (hold_q[i] == LONG_MAX) ? hold_q[i] : hold_q[i] + LONG_W'(1);
        long_d[i] = (hold_q[i] == LONG_FIRE);
      end
    end
  end

  // Hold counter and long-press pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '{default: '0};
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_multi_button_debounce.sv
// Self-checking bench for multi_button_debounce (N_CH=4, DEBOUNCE_CYCLES=4).
module tb_multi_button_debounce;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int LONG = 100;
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] button_in;
  logic [N-1:0] toggle_mode;
  logic [N-1:0] btn_level, press_pulse, release_pulse, led_out, long_press;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  multi_button_debounce #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .CNT_W(16), .LONG_CYCLES(LONG), .LONG_W(16)
  ) dut (
    .clk(clk), .reset(reset), .button_in(button_in), .toggle_mode(toggle_mode),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .led_out(led_out), .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: history of sampled inputs, where each synchroniser stage is one history slot.
  // The level flips when the last D synchronised samples all disagree with it.
  logic [N-1:0] m_hist [0:D];
  logic [N-1:0] m_lvl = '0, m_press = '0, m_rel = '0, m_tog = '0, m_long = '0;
  int           m_cyc = 0;
  int           m_pcyc [N];

  initial for (int i = 0; i <= D; i++) m_hist[i] = '0;
  initial for (int i = 0; i < N; i++) m_pcyc[i] = 0;

  always @(posedge clk) begin : model_upd
    logic [N-1:0] nl, np, nr, nlg;
    bit           all_diff;
    m_cyc <= m_cyc + 1;
    if (!reset) begin
      for (int j = 0; j <= D; j++) m_hist[j] <= '0;
      m_lvl <= '0; m_press <= '0; m_rel <= '0; m_tog <= '0; m_long <= '0;
    end else begin
      nl = m_lvl; np = '0; nr = '0; nlg = '0;
      for (int c = 0; c < N; c++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++)
          if (m_hist[j][c] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          nl[c] = ~m_lvl[c];
          np[c] = nl[c];
          nr[c] = ~nl[c];
        end
        if (np[c]) m_pcyc[c] <= m_cyc + 1;
        nlg[c] = LONG_ON && m_lvl[c] && nl[c] && ((m_cyc + 1 - m_pcyc[c]) == LONG);
      end
      m_hist[0] <= button_in;
      for (int j = 1; j <= D; j++) m_hist[j] <= m_hist[j-1];
      m_lvl <= nl; m_press <= np; m_rel <= nr; m_tog <= m_tog ^ np; m_long <= nlg;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_btn_level", 32'(btn_level), 32'(m_lvl));
      chk("model_press", 32'(press_pulse), 32'(m_press));
      chk("model_release", 32'(release_pulse), 32'(m_rel));
      chk("model_led", 32'(led_out), 32'((toggle_mode & m_tog) | (~toggle_mode & m_lvl)));
      chk("model_long", 32'(long_press), 32'(m_long));
    end
  end

  initial begin
    int n_long, pidx, lidx;
    reset = 1'b0; button_in = '1; toggle_mode = '0;
    tick(); tick();
    chk("reset_all_zero", 32'({btn_level, press_pulse, release_pulse, led_out, long_press}), 32'd0);
    cmp_en = 1'b1;

    // Reset release with all buttons held
    reset = 1'b1;
    repeat (5) tick();
    chk("rst_rel_level_e5", 32'(btn_level), 32'h0);
    tick();
    chk("rst_rel_level_e6", 32'(btn_level), 32'hF);
    chk("rst_rel_press", 32'(press_pulse), 32'hF);
    tick();
    chk("rst_rel_press_once", 32'(press_pulse), 32'h0);
    button_in = '0;
    repeat (8) tick();

    // Bounce on ch0
    button_in[0] = 1'b1; tick(); tick();
    button_in[0] = 1'b0; tick();
    button_in[0] = 1'b1;
    repeat (5) tick();
    chk("bounce_level_hold", 32'(btn_level), 32'h0);
    tick();
    chk("bounce_level_set", 32'(btn_level), 32'h1);
    chk("bounce_press", 32'(press_pulse), 32'h1);
    tick();
    chk("bounce_press_once", 32'(press_pulse), 32'h0);
    button_in[0] = 1'b0;
    repeat (8) tick();

    // Level mode on ch1
    button_in[1] = 1'b1;
    repeat (20) tick();
    chk("lvl_led1_on", 32'(led_out), 32'h2);
    button_in[1] = 1'b0;
    repeat (5) tick();
    chk("rel_not_yet", 32'(release_pulse), 32'h0);
    tick();
    chk("rel_pulse", 32'(release_pulse), 32'h2);
    chk("lvl_led1_off", 32'(led_out), 32'h0);
    tick();
    chk("rel_pulse_once", 32'(release_pulse), 32'h0);

    // Toggle mode on ch2 from a clean reset
    reset = 1'b0; tick(); reset = 1'b1;
    toggle_mode[2] = 1'b1; #1;
    chk("tog_start", 32'(led_out), 32'h0);
    for (int p = 0; p < 3; p++) begin
      button_in[2] = 1'b1;
      repeat (8) tick();
      chk($sformatf("tog_press%0d", p), 32'(led_out), (p % 2 == 0) ? 32'h4 : 32'h0);
      button_in[2] = 1'b0;
      repeat (8) tick();
      chk($sformatf("tog_held%0d", p), 32'(led_out), (p % 2 == 0) ? 32'h4 : 32'h0);
    end
    toggle_mode[2] = 1'b0; #1;
    chk("mode_to_level", 32'(led_out), 32'h0);
    toggle_mode[2] = 1'b1; #1;
    chk("mode_to_toggle", 32'(led_out), 32'h4);

    // Simultaneous press on ch0 and ch3
    button_in = 4'b1001;
    repeat (5) tick();
    chk("simul_press_early", 32'(press_pulse), 32'h0);
    tick();
    chk("simul_press", 32'(press_pulse), 32'h9);
    tick();
    chk("simul_press_once", 32'(press_pulse), 32'h0);
    button_in = '0;
    repeat (8) tick();

    // Reset in the middle of a ch3 count
    button_in[3] = 1'b1;
    repeat (4) tick();
    reset = 1'b0; tick();
    chk("midrst_all_zero", 32'({btn_level, press_pulse, release_pulse, led_out, long_press}), 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    chk("midrst_restart_hold", 32'(btn_level), 32'h0);
    tick();
    chk("midrst_restart_set", 32'(btn_level), 32'h8);
    chk("midrst_press", 32'(press_pulse), 32'h8);
    button_in = '0;
    repeat (8) tick();

    // Long hold on ch1
    n_long = 0; pidx = -1; lidx = -1;
    button_in[1] = 1'b1;
    for (int t = 0; t < 150; t++) begin
      tick();
      if (press_pulse[1]) pidx = t;
      if (long_press[1]) begin n_long++; lidx = t; end
    end
    chk("long_press_idx", 32'(pidx), 32'd5);
`ifdef LONG_PRESS_EN
    chk("long_count", 32'(n_long), 32'd1);
    chk("long_delay", 32'(lidx - pidx), 32'd100);
`else
    chk("long_off", 32'(n_long), 32'd0);
`endif
    button_in[1] = 1'b0;
    repeat (10) tick();

    // Short hold on ch1 must not fire
    n_long = 0;
    button_in[1] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      tick();
      if (long_press[1]) n_long++;
    end
    chk("short_hold_nolong", 32'(n_long), 32'd0);
    button_in[1] = 1'b0;
    repeat (10) tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_button_debounce.md
Name: multi_button_debounce

Overview:
Parametrised N-channel push-button conditioner; next generation of the single-button push_button debouncer.
Per channel: 2-flop synchroniser, stability-counter debounce, press/release edge pulses, per-channel level/toggle LED mode, and optional long-press detection.
Sits between raw board buttons and the control logic/LED drivers; one instance serves a whole button bank.

Parameters:
N_CH, 4, number of independent button channels (>=1)
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the stable state before the stable state changes (>=2)
CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
LONG_CYCLES, 100, cycles stable-high before long_press fires (used only with LONG_PRESS_EN)
LONG_W, 16, long-press counter width; must satisfy 2**LONG_W > LONG_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk rising edge)
button_in  input  N_CH  raw asynchronous button levels, 1 = pressed
toggle_mode  input  N_CH  per-channel LED mode: 0 = level, 1 = toggle (synchronous, no synchroniser)
btn_level  output  N_CH  debounced stable button level
press_pulse  output  N_CH  1-cycle pulse on debounced 0->1
release_pulse  output  N_CH  1-cycle pulse on debounced 1->0
led_out  output  N_CH  LED drive per channel
long_press  output  N_CH  1-cycle pulse when held LONG_CYCLES (0 if feature off)

Behaviour:
- Reset (reset==0 at edge): sync flops, counters, btn_level, toggle state, all pulses, led_out, long_press -> 0. Reset wins over all other events in that cycle.
- Synchroniser: s1 <= button_in; s2 <= s1. Only s2 feeds debounce logic.
- Debounce per channel: if s2 == btn_level, cnt <= 0 (any bounce restarts count). If s2 != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= s2, cnt <= 0. Otherwise cnt <= cnt+1.
- Latency: button_in changes before edge k and holds -> btn_level changes at edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges). Glitch shorter than DEBOUNCE_CYCLES synchronised cycles -> no output change.
- press_pulse/release_pulse: registered, high exactly in the cycle btn_level has just changed (same edge as btn_level update); never both high on one channel.
- Toggle state tog: flips on each press (btn_level 0->1), independent of toggle_mode, so mode changes do not lose state.
- led_out = toggle_mode ? tog : btn_level (combinational mux from registers; mode change takes effect same cycle).
- Channels fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.
- Counters never wrap: debounce cnt cleared at DEBOUNCE_CYCLES-1; long counter saturates.

Optional Feature:
LONG_PRESS_EN: defined -> per-channel hold counter: cleared while btn_level==0; increments while btn_level==1, saturating at LONG_CYCLES; long_press pulses one cycle on the edge counter reaches LONG_CYCLES (once per press); release before that -> no pulse; re-press restarts from 0. Not defined -> no hold counter logic, long_press tied to 0.

Test Plan:
- Reset: hold reset=0 for 2 edges with button_in=4'hF -> all outputs 0; release reset -> btn_level=4'hF after 6 edges (DEBOUNCE_CYCLES=4), press_pulse=4'hF for exactly 1 cycle.
- Bounce reject: ch0 button_in 0->1 for 2 cycles, 0 for 1, then 1 steady -> no change until 6 edges after final rise; then btn_level[0]=1, press_pulse[0] single pulse; other channels idle.
- Release/level mode: toggle_mode=0, ch1 pressed then released after 20 cycles -> led_out[1] follows btn_level[1]; release_pulse[1] one cycle, 6 edges after button_in drop.
- Toggle mode: toggle_mode[2]=1, three clean presses -> led_out[2] sequence 1,0,1; switch toggle_mode[2]=0 while released -> led_out[2]=0 same cycle; back to 1 -> led_out[2]=1.
- Simultaneous + mid-op reset: ch0 and ch3 pressed same cycle -> press_pulse=4'b1001 in one cycle; reset=0 pulsed while ch3 counter mid-count -> all state 0, count restarts from 0 after release.
- LONG_PRESS_EN (LONG_CYCLES=100): hold ch1 150 cycles -> one long_press[1] pulse 100 cycles after press_pulse[1]; hold 50 cycles -> no pulse; without macro long_press stays 0.
